index_decoder: RTL

Streaming inverse of the `Encoder` block: accepts a packet of binary indices over a valid/ready handshake and produces a registered bitmap with one bit set per accepted index. It reports the number of distinct bits set and whether any index repeated within the packet. It sits upstream of `Encoder` wherever a request bitmap must be rebuilt from index traffic. A single-beat packet reproduces the one-hot word that `Encoder` maps back to the same index.

---
 rtl/index_decoder.sv | 93 +++++++++
 1 files changed

// File: rtl/index_decoder.sv
// rtl/index_decoder.sv - rebuilds a bitmap from a packet of streamed indices
module index_decoder #(
  parameter int IN_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_WIDTH-1:0]       in_index,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(1<<IN_WIDTH)-1:0]  out_bits,
  output logic [IN_WIDTH:0]         out_count,
  output logic                      out_dup
);

  localparam int NBITS = 1 << IN_WIDTH;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] EMIT  = 1'b1;

  logic [0:0]        state;
  logic [NBITS-1:0]  acc_bits;
  logic [IN_WIDTH:0] acc_count;
  logic              acc_dup;

  logic              accept;
  logic              hit;
  logic [NBITS-1:0]  one_hot;
  logic [NBITS-1:0]  base_bits;
  logic [IN_WIDTH:0] base_count;
  logic              base_dup;
  logic [NBITS-1:0]  new_bits;
  logic [IN_WIDTH:0] new_count;
  logic              new_dup;

  // Result is held while EMIT; a new beat only enters when that result leaves.
  assign out_valid = (state == EMIT);
  assign in_ready  = (state == ACCUM) || out_ready;
  assign accept    = in_valid && in_ready;

  // Merge the incoming index into the accumulator; in EMIT the accumulator is
  // already clear, so the beat starts a fresh packet.
  always_comb begin
    one_hot = '0;
    one_hot[in_index] = 1'b1;
    if (state == EMIT) begin
      base_bits  = '0;
      base_count = '0;
      base_dup   = 1'b0;
    end else begin
      base_bits  = acc_bits;
      base_count = acc_count;
      base_dup   = acc_dup;
    end
    hit       = |(base_bits & one_hot);
    new_bits  = base_bits | one_hot;
    new_count = hit ? base_count : base_count + {{IN_WIDTH{1'b0}}, 1'b1};
    new_dup   = base_dup | hit;
  end

  // Accumulate non-last beats, publish on the last beat, retire on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc_bits  <= '0;
      acc_count <= '0;
      acc_dup   <= 1'b0;
      out_bits  <= '0;
      out_count <= '0;
      out_dup   <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        out_bits  <= new_bits;
        out_count <= new_count;
        out_dup   <= new_dup;
        acc_bits  <= '0;
        acc_count <= '0;
        acc_dup   <= 1'b0;
        state     <= EMIT;
      end else begin
        acc_bits  <= new_bits;
        acc_count <= new_count;
        acc_dup   <= new_dup;
        state     <= ACCUM;
      end
    end else if ((state == EMIT) && out_ready) begin
      state <= ACCUM;
    end
  end

endmodule
